// File: rtl/wave_pkg.sv
// Shared definitions for the wave generator / meter pair: sample width,
// period counter width, hysteresis defaults and the meter FSM state encoding.
package wave_pkg;

  localparam int DATA_W_DEF   = 8;
  localparam int PERIOD_W_DEF = 16;
  localparam int HYST_DEF     = 8;

  typedef enum logic [1:0] {
    SEEK_LOW  = 2'd0,
    SEEK_RISE = 2'd1,
    RUN_HIGH  = 2'd2,
    RUN_LOW   = 2'd3
  } meter_state_e;

endpackage

// File: rtl/wave_minmax_track.sv
// Running minimum/maximum of the accepted samples in the current window.
// init loads both registers with the sample; update folds the sample in.
module wave_minmax_track
  import wave_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init,
  input  logic              update,
  input  logic [DATA_W-1:0] sample,
  output logic [DATA_W-1:0] min_val,
  output logic [DATA_W-1:0] max_val
);

  // Window extrema; init takes priority over update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_val <= {DATA_W{1'b0}};
      max_val <= {DATA_W{1'b0}};
    end else if (init) begin
      min_val <= sample;
      max_val <= sample;
    end else if (update) begin
      if (sample < min_val) min_val <= sample;
      else                  min_val <= min_val;
      if (sample > max_val) max_val <= sample;
      else                  max_val <= max_val;
    end else begin
      min_val <= min_val;
      max_val <= max_val;
    end
  end

endmodule

// File: rtl/wave_meter.sv
// Period / min / max meter for an unsigned sample stream, using a hysteretic
// threshold crossing detector to delimit each waveform cycle.
module wave_meter
  import wave_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int PERIOD_W = PERIOD_W_DEF,
  parameter int HYST     = HYST_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic [DATA_W-1:0]   sample_in,
  input  logic                sample_valid,
  input  logic [DATA_W-1:0]   threshold,
  output logic [PERIOD_W-1:0] period_out,
  output logic [DATA_W-1:0]   min_out,
  output logic [DATA_W-1:0]   max_out,
  output logic                meas_valid,
  output logic                locked,
  output logic                timeout
);

  localparam logic [DATA_W:0]   HYST_EXT = (DATA_W+1)'(HYST);
  localparam logic [PERIOD_W-1:0] CNT_ONE  = {{(PERIOD_W-1){1'b0}}, 1'b1};
  // Last count value a window may hold; one more sample would hit all-ones
  localparam logic [PERIOD_W-1:0] CNT_LAST = {{(PERIOD_W-1){1'b1}}, 1'b0};

  meter_state_e        state_r, state_next_s;
  logic [PERIOD_W-1:0] cnt_r, cnt_next_s;
  logic [DATA_W:0]     thr_ext_s, hi_sum_s;
  logic [DATA_W-1:0]   hi_s, lo_s, run_min_s, run_max_s;
  logic                accept_s, is_low_s, is_high_s;
  logic                mm_init_s, mm_update_s, close_s, expire_s;

  // Saturated hysteresis band edges and sample classification
  always_comb begin
    thr_ext_s = {1'b0, threshold};
    hi_sum_s  = thr_ext_s + HYST_EXT;
    if (hi_sum_s[DATA_W]) hi_s = {DATA_W{1'b1}};
    else                  hi_s = hi_sum_s[DATA_W-1:0];
    if (thr_ext_s < HYST_EXT) lo_s = {DATA_W{1'b0}};
    else                      lo_s = threshold - HYST_EXT[DATA_W-1:0];
    accept_s  = ena & sample_valid;
    is_low_s  = (sample_in <= lo_s);
    is_high_s = (sample_in >= hi_s);
  end

  // Next-state, counter and tracker control
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    mm_init_s    = 1'b0;
    mm_update_s  = 1'b0;
    close_s      = 1'b0;
    expire_s     = 1'b0;
    if (accept_s) begin
      case (state_r)
        SEEK_LOW: begin
          if (is_low_s) state_next_s = SEEK_RISE;
          else          state_next_s = SEEK_LOW;
        end
        SEEK_RISE: begin
          if (is_high_s) begin
            state_next_s = RUN_HIGH;
            cnt_next_s   = {PERIOD_W{1'b0}};
            mm_init_s    = 1'b1;
          end else begin
            state_next_s = SEEK_RISE;
          end
        end
        RUN_HIGH: begin
          if (cnt_r == CNT_LAST) begin
            expire_s     = 1'b1;
            state_next_s = SEEK_LOW;
            cnt_next_s   = {PERIOD_W{1'b0}};
          end else begin
            mm_update_s = 1'b1;
            cnt_next_s  = cnt_r + CNT_ONE;
            if (is_low_s) state_next_s = RUN_LOW;
            else          state_next_s = RUN_HIGH;
          end
        end
        RUN_LOW: begin
          // A crossing closes the window even when the counter is at its limit
          if (is_high_s) begin
            close_s      = 1'b1;
            mm_init_s    = 1'b1;
            cnt_next_s   = {PERIOD_W{1'b0}};
            state_next_s = RUN_HIGH;
          end else if (cnt_r == CNT_LAST) begin
            expire_s     = 1'b1;
            state_next_s = SEEK_LOW;
            cnt_next_s   = {PERIOD_W{1'b0}};
          end else begin
            mm_update_s = 1'b1;
            cnt_next_s  = cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_next_s = SEEK_LOW;
          cnt_next_s   = {PERIOD_W{1'b0}};
        end
      endcase
    end else begin
      state_next_s = state_r;
    end
  end

  // FSM state and sample counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= SEEK_LOW;
      cnt_r   <= {PERIOD_W{1'b0}};
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

  wave_minmax_track #(
    .DATA_W (DATA_W)
  ) u_minmax (
    .clk     (clk),
    .rst_n   (rst_n),
    .init    (mm_init_s),
    .update  (mm_update_s),
    .sample  (sample_in),
    .min_val (run_min_s),
    .max_val (run_max_s)
  );

  // Published results and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_out <= {PERIOD_W{1'b0}};
      min_out    <= {DATA_W{1'b0}};
      max_out    <= {DATA_W{1'b0}};
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      meas_valid <= close_s;
      if (close_s) begin
        period_out <= cnt_r + CNT_ONE;
        min_out    <= run_min_s;
        max_out    <= run_max_s;
        locked     <= 1'b1;
        timeout    <= 1'b0;
      end else if (expire_s) begin
        locked     <= 1'b0;
        timeout    <= 1'b1;
      end else begin
        locked     <= locked;
        timeout    <= timeout;
      end
    end
  end

endmodule

// File: tb/tb_wave_meter.sv
// Directed bench for wave_meter (PERIOD_W=6 so the timeout is reachable):
// table of square-wave scenarios plus hand-written multi-cycle sequences.
module tb_wave_meter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] sample_in = 8'd0;
  logic       sample_valid = 1'b0;
  logic [7:0] threshold = 8'd100;
  logic [5:0] period_out;
  logic [7:0] min_out, max_out;
  logic       meas_valid, locked, timeout;

  int total = 0;
  int bad = 0;
  int mv_count = 0;
  int cyc = 0;
  int last_ev_cyc = 0;
  int prev_ev_cyc = 0;

  wave_meter #(.DATA_W(8), .PERIOD_W(6), .HYST(8)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .sample_in(sample_in),
    .sample_valid(sample_valid), .threshold(threshold),
    .period_out(period_out), .min_out(min_out), .max_out(max_out),
    .meas_valid(meas_valid), .locked(locked), .timeout(timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int thr; int lo_v; int hi_v; int nl; int nh;
    int exp_ev; int exp_period; int exp_min; int exp_max; int exp_locked;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // One clock with the given inputs; outputs sampled 1ns after the edge
  task automatic drive(input int s, input logic v, input logic e);
    sample_in = 8'(s);
    sample_valid = v;
    ena = e;
    @(posedge clk);
    #1;
    if (meas_valid === 1'b1) begin
      mv_count++;
      prev_ev_cyc = last_ev_cyc;
      last_ev_cyc = cyc;
    end
  endtask

  task automatic square(input int lo_v, input int hi_v, input int nl, input int nh, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      for (int i = 0; i < nl; i++) drive(lo_v, 1'b1, 1'b1);
      for (int i = 0; i < nh; i++) drive(hi_v, 1'b1, 1'b1);
    end
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  task automatic chk_results(input string tag, input int p, input int mn, input int mx);
    chk({tag, "_period"}, 32'(period_out), 32'(p));
    chk({tag, "_min"}, 32'(min_out), 32'(mn));
    chk({tag, "_max"}, 32'(max_out), 32'(mx));
  endtask

  initial begin
    int base;
    vecs[0] = '{100,   0, 200, 5, 5, 3, 10,  0, 200, 1};
    vecs[1] = '{100,   0, 200, 3, 7, 3, 10,  0, 200, 1};
    vecs[2] = '{ 50,  40,  60, 6, 2, 3,  8, 40,  60, 1};
    vecs[3] = '{250,   0, 255, 4, 4, 3,  8,  0, 255, 1};
    vecs[4] = '{  3,   0,  20, 2, 3, 3,  5,  0,  20, 1};
    vecs[5] = '{120,  10, 130, 1, 1, 3,  2, 10, 130, 1};
    vecs[6] = '{100,  92, 108, 5, 5, 3, 10, 92, 108, 1};
    vecs[7] = '{100,  93, 200, 5, 5, 0,  0,  0,   0, 0};

    // reset state
    #12;
    chk("rst_period", 32'(period_out), 32'd0);
    chk("rst_min", 32'(min_out), 32'd0);
    chk("rst_max", 32'(max_out), 32'd0);
    chk("rst_mv", 32'(meas_valid), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    rst_n = 1'b1;

    // table-driven square waves
    for (int k = 0; k < 8; k++) begin
      pulse_reset();
      threshold = 8'(vecs[k].thr);
      base = mv_count;
      square(vecs[k].lo_v, vecs[k].hi_v, vecs[k].nl, vecs[k].nh, 4);
      chk($sformatf("vec%0d_events", k), 32'(mv_count - base), 32'(vecs[k].exp_ev));
      chk_results($sformatf("vec%0d", k), vecs[k].exp_period, vecs[k].exp_min, vecs[k].exp_max);
      chk($sformatf("vec%0d_locked", k), 32'(locked), 32'(vecs[k].exp_locked));
    end

    // triangle 0..255..17, 30-sample period
    pulse_reset();
    threshold = 8'd128;
    base = mv_count;
    for (int n = 0; n < 90; n++) begin
      int i;
      i = n % 30;
      drive((i <= 15) ? 17 * i : 17 * (30 - i), 1'b1, 1'b1);
    end
    chk("tri_events", 32'(mv_count - base), 32'd2);
    chk_results("tri", 30, 0, 255);

    // noise inside the hysteresis band must not add crossings
    pulse_reset();
    threshold = 8'd100;
    base = mv_count;
    for (int c = 0; c < 5; c++) begin
      drive(0, 1'b1, 1'b1); drive(0, 1'b1, 1'b1); drive(106, 1'b1, 1'b1);
      drive(94, 1'b1, 1'b1); drive(0, 1'b1, 1'b1);
      drive(200, 1'b1, 1'b1); drive(94, 1'b1, 1'b1); drive(106, 1'b1, 1'b1);
      drive(200, 1'b1, 1'b1); drive(200, 1'b1, 1'b1);
    end
    chk("noise_events", 32'(mv_count - base), 32'd4);
    chk_results("noise", 10, 0, 200);

    // valid every third clock; invalid slots carry a would-be crossing value
    pulse_reset();
    base = mv_count;
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 10; i++) begin
        drive((i < 5) ? 0 : 200, 1'b1, 1'b1);
        drive(255, 1'b0, 1'b1);
        drive(255, 1'b0, 1'b1);
      end
    end
    chk("gap_events", 32'(mv_count - base), 32'd3);
    chk("gap_spacing", 32'(last_ev_cyc - prev_ev_cyc), 32'd30);
    chk_results("gap", 10, 0, 200);

    // timeout: window holds cnt=4 here; the 59th constant sample hits the limit
    base = mv_count;
    for (int i = 0; i < 58; i++) drive(50, 1'b1, 1'b1);
    chk("pre_tmo_timeout", 32'(timeout), 32'd0);
    chk("pre_tmo_locked", 32'(locked), 32'd1);
    drive(50, 1'b1, 1'b1);
    chk("tmo_timeout", 32'(timeout), 32'd1);
    chk("tmo_locked", 32'(locked), 32'd0);
    chk("tmo_events", 32'(mv_count - base), 32'd0);
    chk_results("tmo_hold", 10, 0, 200);
    square(0, 200, 5, 5, 2);
    chk("resume_events", 32'(mv_count - base), 32'd1);
    chk("resume_timeout", 32'(timeout), 32'd0);
    chk("resume_locked", 32'(locked), 32'd1);
    chk("resume_period", 32'(period_out), 32'd10);

    // ena freeze mid-window with crossing-level samples presented
    pulse_reset();
    base = mv_count;
    square(0, 200, 5, 5, 2);
    drive(0, 1'b1, 1'b1); drive(0, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) drive(200, 1'b1, 1'b0);
    chk("frz_events", 32'(mv_count - base), 32'd1);
    for (int i = 0; i < 3; i++) drive(0, 1'b1, 1'b1);
    drive(200, 1'b1, 1'b1);
    chk("frz_close_events", 32'(mv_count - base), 32'd2);
    chk("frz_period", 32'(period_out), 32'd10);

    // asynchronous reset mid-window, then full re-acquisition
    drive(200, 1'b1, 1'b1); drive(200, 1'b1, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_period", 32'(period_out), 32'd0);
    chk("arst_max", 32'(max_out), 32'd0);
    chk("arst_locked", 32'(locked), 32'd0);
    #2 rst_n = 1'b1;
    base = mv_count;
    for (int i = 0; i < 5; i++) drive(0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) drive(200, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) drive(0, 1'b1, 1'b1);
    chk("reacq_none", 32'(mv_count - base), 32'd0);
    drive(200, 1'b1, 1'b1);
    chk("reacq_first", 32'(mv_count - base), 32'd1);
    chk_results("reacq", 10, 0, 200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
